flexbyte_pts_sr: RTL and testbench

Flexible parallel-to-serial multibyte shift register. It is the transmit-side counterpart of the flexbyte serial-to-parallel register: it accepts one wide word of NUM_BYTES_IN bytes and emits it as successive NUM_BYTES_OUT-byte chunks. Both the load side and the output side use valid/ready handshakes, so the block sits between a packet buffer and a narrow serializer or encoder. A variable chunk count per load supports short final words.

---
 rtl/flexbyte_pkg.sv | 15 +
 rtl/flexbyte_pts_sr_if.sv | 34 +++
 rtl/flexbyte_pts_sr.sv | 74 +++++++
 tb/tb_flexbyte_pts_sr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/flexbyte_pkg.sv
// flexbyte_pkg: sizing helpers shared by the flexbyte serial/parallel
// shift registers (pts and stp sides).
//   ratio_f(nin, nout) : chunks per wide word
//   cw_f(ratio)        : width of a chunk counter able to hold 0..ratio
package flexbyte_pkg;

  function automatic int ratio_f(input int nin, input int nout);
    return nin / nout;
  endfunction

  function automatic int cw_f(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/flexbyte_pts_sr_if.sv
// flexbyte_pts_sr_if: load and output handshakes of the parallel-to-serial
// register.
//   load_valid/load_ready/load_data/load_len : wide word in
//   out_valid/out_ready/data_out/last        : chunk stream out
//   busy                                     : word in flight
// slave  = the shift register, master = the surrounding logic / bench.
interface flexbyte_pts_sr_if
  import flexbyte_pkg::*;
#(
  parameter int NUM_BYTES_IN  = 4,
  parameter int NUM_BYTES_OUT = 1
);
  localparam int CW = cw_f(ratio_f(NUM_BYTES_IN, NUM_BYTES_OUT));

  logic                       load_valid;
  logic                       load_ready;
  logic [NUM_BYTES_IN*8-1:0]  load_data;
  logic [CW-1:0]              load_len;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_BYTES_OUT*8-1:0] data_out;
  logic                       last;
  logic                       busy;

  modport slave (
    input  load_valid, load_data, load_len, out_ready,
    output load_ready, out_valid, data_out, last, busy
  );

  modport master (
    output load_valid, load_data, load_len, out_ready,
    input  load_ready, out_valid, data_out, last, busy
  );
endinterface

// File: rtl/flexbyte_pts_sr.sv
// flexbyte_pts_sr: loads one NUM_BYTES_IN-byte word and emits it as
// NUM_BYTES_OUT-byte chunks, MSB chunk first (MSB=1) or LSB chunk first.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : flexbyte_pts_sr_if.slave (load and output handshakes, busy)
// rem counts chunks still to emit; rem==0 is the empty state.
module flexbyte_pts_sr
  import flexbyte_pkg::*;
#(
  parameter bit MSB           = 1'b1,
  parameter int NUM_BYTES_IN  = 4,
  parameter int NUM_BYTES_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  flexbyte_pts_sr_if.slave   bus
);
  localparam int W     = NUM_BYTES_IN * 8;
  localparam int OW    = NUM_BYTES_OUT * 8;
  localparam int RATIO = ratio_f(NUM_BYTES_IN, NUM_BYTES_OUT);
  localparam int CW    = cw_f(RATIO);

  if (NUM_BYTES_IN <= NUM_BYTES_OUT) begin : g_chk_w
    $fatal(1, "flexbyte_pts_sr: NUM_BYTES_IN must exceed NUM_BYTES_OUT");
  end
  if (NUM_BYTES_IN % NUM_BYTES_OUT != 0) begin : g_chk_div
    $fatal(1, "flexbyte_pts_sr: NUM_BYTES_IN must be a multiple of NUM_BYTES_OUT");
  end

  logic [W-1:0]  shreg, shreg_nxt;
  logic [CW-1:0] rem, rem_nxt, len_eff;
  logic [OW-1:0] chunk;
  logic          out_valid, load_ready, pop, ld;

  always_comb begin
    // Out-of-range lengths fall back to a full word.
    len_eff    = (bus.load_len == '0 || bus.load_len > CW'(RATIO)) ? CW'(RATIO)
                                                                    : bus.load_len;
    out_valid  = (rem != '0);
    // Accept the next word while the final chunk leaves: no bubble.
    load_ready = (rem == '0) || (rem == CW'(1) && bus.out_ready);
    pop        = out_valid && bus.out_ready;
    ld         = bus.load_valid && load_ready;
    chunk      = MSB ? shreg[W-1 -: OW] : shreg[OW-1:0];
    shreg_nxt  = shreg;
    rem_nxt    = rem;
    if (ld) begin
      // A load coinciding with the last pop overwrites both fields.
      shreg_nxt = bus.load_data;
      rem_nxt   = len_eff;
    end else if (pop) begin
      shreg_nxt = MSB ? (shreg << OW) : (shreg >> OW);
      rem_nxt   = rem - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      rem   <= '0;
    end else begin
      shreg <= shreg_nxt;
      rem   <= rem_nxt;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = out_valid;
  assign bus.last       = (rem == CW'(1));
  // Stale or discarded bytes never leak out while idle.
  assign bus.data_out   = out_valid ? chunk : '0;

endmodule

// File: tb/tb_flexbyte_pts_sr.sv
// Bench for flexbyte_pts_sr: one MSB-first and one LSB-first instance run
// in lockstep. Each accepted word is expanded into its expected chunk list
// (pushed into a per-instance queue); a negedge monitor compares every
// output against the queue front.
module tb_flexbyte_pts_sr;
  localparam int NI = 4;
  localparam int NO = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv;
  logic [31:0] ldat;
  logic [2:0] llen;
  logic       ordy;
  logic       chk_en = 1'b0;

  always #5 clk = ~clk;

  flexbyte_pts_sr_if #(.NUM_BYTES_IN(NI), .NUM_BYTES_OUT(NO)) b1 ();
  flexbyte_pts_sr_if #(.NUM_BYTES_IN(NI), .NUM_BYTES_OUT(NO)) b0 ();

  assign b1.load_valid = lv;  assign b0.load_valid = lv;
  assign b1.load_data  = ldat; assign b0.load_data = ldat;
  assign b1.load_len   = llen; assign b0.load_len  = llen;
  assign b1.out_ready  = ordy; assign b0.out_ready = ordy;

  flexbyte_pts_sr #(.MSB(1'b1), .NUM_BYTES_IN(NI), .NUM_BYTES_OUT(NO))
    u_msb (.clk(clk), .rst(rst), .bus(b1));
  flexbyte_pts_sr #(.MSB(1'b0), .NUM_BYTES_IN(NI), .NUM_BYTES_OUT(NO))
    u_lsb (.clk(clk), .rst(rst), .bus(b0));

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t q1[$];
  exp_t q0[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // Reference: word -> ordered chunk list, straight from the length rules.
  task automatic push_word(input bit msb, input logic [31:0] w, input logic [2:0] len);
    int n;
    exp_t e;
    n = (len == 0 || len > 4) ? 4 : int'(len);
    for (int i = 0; i < n; i++) begin
      e.d = msb ? w[8*(3-i) +: 8] : w[8*i +: 8];
      e.l = (i == n - 1);
      if (msb) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic check_side(input bit msb, input string tag, input logic ov,
                            input logic [7:0] dout, input logic lst,
                            input logic bsy, input logic lrdy);
    int n;
    exp_t f;
    n = msb ? q1.size() : q0.size();
    f.d = 8'h00; f.l = 1'b0;
    if (n > 0) f = msb ? q1[0] : q0[0];
    chk({tag, ".out_valid"}, ov, (n != 0));
    chk({tag, ".busy"}, bsy, (n != 0));
    chk({tag, ".data_out"}, dout, f.d);
    chk({tag, ".last"}, lst, f.l);
    chk({tag, ".load_ready"}, lrdy, (n == 0) || (n == 1 && ordy));
  endtask

  // Monitor: compare, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit exp_lr, pop1, pop0;
    if (chk_en) begin
      check_side(1'b1, "msb", b1.out_valid, b1.data_out, b1.last, b1.busy, b1.load_ready);
      check_side(1'b0, "lsb", b0.out_valid, b0.data_out, b0.last, b0.busy, b0.load_ready);
    end
    exp_lr = (q1.size() == 0) || (q1.size() == 1 && ordy);
    pop1 = (q1.size() != 0) && ordy;
    pop0 = (q0.size() != 0) && ordy;
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (pop0) void'(q0.pop_front());
      if (lv && exp_lr) begin
        push_word(1'b1, ldat, llen);
        push_word(1'b0, ldat, llen);
      end
    end
  end

  // Present a word and hold it until the DUT takes it.
  task automatic send(input logic [31:0] w, input logic [2:0] len);
    bit acc;
    int t;
    lv = 1'b1; ldat = w; llen = len;
    t = 0;
    do begin
      @(negedge clk);
      acc = b1.load_ready;
      @(posedge clk);
      t++;
    end while (!acc && t < 200);
    #1;
    lv = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL load_timeout act=%0d exp=accept", t);
    end
  endtask

  task automatic drain();
    int t;
    ordy = 1'b1;
    t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    tests++;
    if (q1.size() != 0 || q0.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout act=%0d exp=0", q1.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc;
    rst = 1'b1; lv = 1'b0; ldat = '0; llen = '0; ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;             // reset state checked at next negedge
    @(posedge clk); #1 rst = 1'b0;

    // 1/2: full word, both orders, free-running consumer
    send(32'hA1B2C3D4, 3'd4);
    drain();

    // 3: back-to-back words, zero bubble
    send(32'h11223344, 3'd4);
    send(32'h55667788, 3'd4);
    drain();

    // 4: three stalled cycles while B2 is presented
    send(32'hA1B2C3D4, 3'd4);
    @(posedge clk); #1 ordy = 1'b0;
    repeat (3) @(posedge clk);
    #1 ordy = 1'b1;
    drain();

    // 5: partial and out-of-range lengths
    send(32'hA1B2C3D4, 3'd2);
    drain();
    send(32'hA1B2C3D4, 3'd0);
    drain();
    send(32'hCAFEF00D, 3'd7);
    drain();
    send(32'h01020304, 3'd1);
    drain();

    // 6: reset mid-word, then reset racing a load
    send(32'hA1B2C3D4, 3'd4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    lv = 1'b1; ldat = 32'hDEADBEEF; llen = 3'd4; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; lv = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = lv && b1.load_ready;
      @(posedge clk); #1;
      if (acc || !lv) begin
        lv   = ($urandom_range(0, 2) != 0);
        ldat = $urandom;
        llen = 3'($urandom_range(0, 7));
      end
      ordy = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = lv && b1.load_ready;
    @(posedge clk); #1;
    lv = 1'b0;
    if (!acc) begin
      // An unaccepted pending word is simply withdrawn.
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
